mmio_host_arbiter: RTL
======================

# mmio_host_arbiter

Shares the single TIA MMIO host port among `NUM_HOSTS` requesters, for example the AXI4-Lite bridge and an on-chip debug or DMA engine. One read or write transaction is in flight at a time. Requests are latched, forwarded on `host_interface`, and the response is returned to the granted requester. Grants are round-robin across hosts, and a watchdog retires transactions the fabric never acknowledges.

## Interface
Parameters:
- `NUM_HOSTS`, default 2: number of upstream requesters (≥1).
- `TIMEOUT_CYCLES`, default 255: BUSY-state cycles before forced retirement; 0 disables the watchdog.

Ports:
- `clock`  in  1  single clock, positive edge.
- `reset`  in  1  synchronous, active-high.
- `req_read_req`  in  NUM_HOSTS  per-host read request.
- `req_read_ack`  out  NUM_HOSTS  per-host read acknowledge pulse.
- `req_read_index`  in  NUM_HOSTS×TIA_MMIO_INDEX_WIDTH  packed, host h at slice h.
- `req_read_data`  out  TIA_MMIO_DATA_WIDTH  shared; valid only with an ack bit.
- `req_write_req`  in  NUM_HOSTS  per-host write request.
- `req_write_ack`  out  NUM_HOSTS  per-host write acknowledge pulse.
- `req_write_index`  in  NUM_HOSTS×TIA_MMIO_INDEX_WIDTH  packed.
- `req_write_data`  in  NUM_HOSTS×TIA_MMIO_DATA_WIDTH  packed.
- `timeout_error`  out  1  one-cycle pulse on watchdog retirement.
- `host_interface`  mmio_if.host  downstream MMIO port.

## Operation
- Upstream handshake: a requester holds req, index and data stable until it samples ack=1, then drops req on the next cycle.
- Within one host, read wins over write when both are asserted.
- FSM IDLE → BUSY → RESPOND → IDLE.
- IDLE:
  - Scan hosts starting at `rr_ptr` for the first host with a read or write req.
  - Latch host id, kind, index and write data into registers.
  - Go to BUSY. Stay in IDLE if no request is pending.
- BUSY:
  - Drive `host_interface` read_req or write_req = 1, with index and data taken from the latched registers only.
  - On downstream ack: capture read_data, deassert downstream req, go to RESPOND.
  - Watchdog: the counter increments each BUSY cycle. When it reaches TIMEOUT_CYCLES with no ack, deassert req, set captured data to all-ones, flag timeout, go to RESPOND.
- RESPOND:
  - Assert the granted host's ack bit of the latched kind for exactly one cycle, with `req_read_data` = captured data.
  - Pulse `timeout_error` if flagged.
  - Set `rr_ptr` = granted+1 mod NUM_HOSTS. Go to IDLE.
- A downstream ack arriving outside BUSY (a late ack after a timeout) is ignored.
- Upstream req changes while in BUSY or RESPOND do not affect the in-flight transaction.
- Reset (any state): FSM to IDLE, `rr_ptr`=0, counter=0. In-flight transaction is dropped with no upstream ack.

## Timing
- Every output is 0 during and after reset: all acks, `req_read_data`, `timeout_error`, downstream req/index/data.
- Request seen at edge n puts downstream req high in cycle n+1.
- Downstream ack sampled at edge m gives the upstream ack in cycle m+1.
- Minimum latency from upstream req to upstream ack is 3 cycles with a single-cycle-ack device.
- The ack pulse coincides with the requester's req still high. The arbiter is in IDLE the following cycle and sees that req low.
- Back-to-back transactions: at most 1 idle cycle between a RESPOND and the next BUSY.
- A host that keeps requesting waits at most NUM_HOSTS−1 transactions.
- Timeout: retirement occurs TIMEOUT_CYCLES cycles after BUSY entry, response one cycle later.
- NUM_HOSTS=1: `rr_ptr` stays 0.

## Structure
- TIA_MMIO_INDEX_WIDTH and TIA_MMIO_DATA_WIDTH come from `mmio.svh`.
- Add the FSM state enum `mmio_arbiter_state_t` (IDLE, BUSY, RESPOND) to `mmio.svh`.
- One sub-module, `round_robin_picker`: combinational, takes a request vector and a pointer, outputs a one-hot grant plus a valid bit. Reusable elsewhere.

## Test plan
- Host0 read, index 5, device acks in 1 cycle with 0x1234 → `req_read_ack[0]` pulses exactly once, 3 cycles after req, with data 0x1234; host1 ack stays 0.
- Hosts 0 and 1 both write continuously (index 2, data 0xA / index 3, data 0xB) → downstream writes alternate 0,1,0,1; each ack goes to the correct host.
- Host0 asserts read and write together → read issued first, write next.
- TIMEOUT_CYCLES=4, device never acks → downstream req high 4 cycles, then read ack with 0xFFFFFFFF and `timeout_error` pulse. A late device ack is ignored.
- Reset asserted in BUSY → next cycle all outputs 0, state IDLE; a re-issued request from host1 is served first.
- Host changes index while BUSY → downstream index stays at the latched value.

Source files
------------

// File: rtl/mmio_host_arbiter_pkg.sv
// Shared MMIO widths, arbiter FSM state encoding and transaction kind.
package mmio_host_arbiter_pkg;

   localparam int TIA_MMIO_INDEX_WIDTH = 8;
   localparam int TIA_MMIO_DATA_WIDTH  = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESPOND = 2'd2
   } mmio_arbiter_state_t;

   typedef enum logic {
      KIND_READ  = 1'b0,
      KIND_WRITE = 1'b1
   } mmio_kind_t;

endpackage

// File: rtl/mmio_if.sv
// Downstream TIA MMIO port: the host side issues requests, the device acks.
interface mmio_if;

   logic                                                read_req;
   logic [mmio_host_arbiter_pkg::TIA_MMIO_INDEX_WIDTH-1:0] read_index;
   logic                                                read_ack;
   logic [mmio_host_arbiter_pkg::TIA_MMIO_DATA_WIDTH-1:0]  read_data;
   logic                                                write_req;
   logic [mmio_host_arbiter_pkg::TIA_MMIO_INDEX_WIDTH-1:0] write_index;
   logic [mmio_host_arbiter_pkg::TIA_MMIO_DATA_WIDTH-1:0]  write_data;
   logic                                                write_ack;

   modport host (
      output read_req, read_index, write_req, write_index, write_data,
      input  read_ack, read_data, write_ack
   );

   modport device (
      input  read_req, read_index, write_req, write_index, write_data,
      output read_ack, read_data, write_ack
   );

endinterface

// File: rtl/mmio_host_arbiter_round_robin_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module round_robin_picker #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          valid
);

   logic [PW:0]   pos_s;
   logic [PW-1:0] idx_s;
   logic          found_s;

   // Walk the request vector circularly from ptr and grant the first hit.
   always_comb begin
      grant   = '0;
      found_s = 1'b0;
      pos_s   = '0;
      idx_s   = '0;
      for (int i = 0; i < N; i++) begin
         pos_s = {1'b0, ptr} + (PW+1)'(i);
         if (pos_s >= (PW+1)'(N)) begin
            pos_s = pos_s - (PW+1)'(N);
         end else begin
            pos_s = pos_s;
         end
         idx_s = pos_s[PW-1:0];
         if (!found_s && req[idx_s]) begin
            grant[idx_s] = 1'b1;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      valid = found_s;
   end

endmodule

// File: rtl/mmio_host_arbiter.sv
// Round-robin arbiter sharing one MMIO host port among several requesters,
// one transaction in flight, with a watchdog for unacknowledged accesses.
module mmio_host_arbiter
   import mmio_host_arbiter_pkg::*;
#(
   parameter int NUM_HOSTS      = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic [NUM_HOSTS-1:0]                          req_read_req,
   output logic [NUM_HOSTS-1:0]                          req_read_ack,
   input  logic [NUM_HOSTS*TIA_MMIO_INDEX_WIDTH-1:0]     req_read_index,
   output logic [TIA_MMIO_DATA_WIDTH-1:0]                req_read_data,
   input  logic [NUM_HOSTS-1:0]                          req_write_req,
   output logic [NUM_HOSTS-1:0]                          req_write_ack,
   input  logic [NUM_HOSTS*TIA_MMIO_INDEX_WIDTH-1:0]     req_write_index,
   input  logic [NUM_HOSTS*TIA_MMIO_DATA_WIDTH-1:0]      req_write_data,
   output logic                                          timeout_error,
   mmio_if.host                                          host_interface
);

   localparam int IW = TIA_MMIO_INDEX_WIDTH;
   localparam int DW = TIA_MMIO_DATA_WIDTH;
   localparam int PW = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [PW-1:0] LAST_HOST = PW'(NUM_HOSTS - 1);

   mmio_arbiter_state_t state_r, state_s;
   mmio_kind_t          kind_r, kind_s;
   logic [PW-1:0]       gid_r, gid_s, rr_ptr_r, rr_ptr_s, pick_id_s;
   logic [IW-1:0]       idx_r, idx_s;
   logic [DW-1:0]       wdata_r, wdata_s, rdata_r, rdata_s;
   logic [CW-1:0]       cnt_r, cnt_s;
   logic                dn_rreq_r, dn_rreq_s, dn_wreq_r, dn_wreq_s;
   logic                tmo_r, tmo_s, dn_ack_s, retire_s, pick_valid_s;
   logic [NUM_HOSTS-1:0] rack_r, rack_s, wack_r, wack_s, pick_grant_s;

   round_robin_picker #(.N(NUM_HOSTS), .PW(PW)) u_picker (
      .req   (req_read_req | req_write_req),
      .ptr   (rr_ptr_r),
      .grant (pick_grant_s),
      .valid (pick_valid_s)
   );

   // Convert the one-hot grant to a host id.
   always_comb begin
      pick_id_s = '0;
      for (int i = 0; i < NUM_HOSTS; i++) begin
         pick_id_s = pick_id_s | (pick_grant_s[i] ? PW'(i) : '0);
      end
   end

   // Next-state and next-value logic for the whole transaction datapath.
   always_comb begin
      state_s   = state_r;
      kind_s    = kind_r;
      gid_s     = gid_r;
      idx_s     = idx_r;
      wdata_s   = wdata_r;
      cnt_s     = cnt_r;
      rr_ptr_s  = rr_ptr_r;
      dn_rreq_s = dn_rreq_r;
      dn_wreq_s = dn_wreq_r;
      rack_s    = '0;
      wack_s    = '0;
      rdata_s   = '0;
      tmo_s     = 1'b0;
      dn_ack_s  = 1'b0;
      retire_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (pick_valid_s) begin
               gid_s   = pick_id_s;
               cnt_s   = '0;
               state_s = BUSY;
               if (req_read_req[pick_id_s]) begin
                  kind_s    = KIND_READ;
                  idx_s     = req_read_index[pick_id_s*IW +: IW];
                  wdata_s   = '0;
                  dn_rreq_s = 1'b1;
                  dn_wreq_s = 1'b0;
               end else begin
                  kind_s    = KIND_WRITE;
                  idx_s     = req_write_index[pick_id_s*IW +: IW];
                  wdata_s   = req_write_data[pick_id_s*DW +: DW];
                  dn_rreq_s = 1'b0;
                  dn_wreq_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            if (kind_r == KIND_READ) begin
               dn_ack_s = host_interface.read_ack;
            end else begin
               dn_ack_s = host_interface.write_ack;
            end
            if (dn_ack_s) begin
               rdata_s  = (kind_r == KIND_READ) ? host_interface.read_data : '0;
               retire_s = 1'b1;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LAST)) begin
               rdata_s  = '1;
               tmo_s    = 1'b1;
               retire_s = 1'b1;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
            if (retire_s) begin
               dn_rreq_s = 1'b0;
               dn_wreq_s = 1'b0;
               state_s   = RESPOND;
               if (kind_r == KIND_READ) begin
                  rack_s[gid_r] = 1'b1;
               end else begin
                  wack_s[gid_r] = 1'b1;
               end
            end else begin
               state_s = BUSY;
            end
         end
         RESPOND: begin
            cnt_s    = '0;
            rr_ptr_s = (gid_r == LAST_HOST) ? '0 : gid_r + PW'(1);
            state_s  = IDLE;
         end
         default: begin
            dn_rreq_s = 1'b0;
            dn_wreq_s = 1'b0;
            state_s   = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Latched transaction, pointer, watchdog and registered output state.
   always_ff @(posedge clock) begin
      if (reset) begin
         kind_r    <= KIND_READ;
         gid_r     <= '0;
         idx_r     <= '0;
         wdata_r   <= '0;
         cnt_r     <= '0;
         rr_ptr_r  <= '0;
         dn_rreq_r <= 1'b0;
         dn_wreq_r <= 1'b0;
         rack_r    <= '0;
         wack_r    <= '0;
         rdata_r   <= '0;
         tmo_r     <= 1'b0;
      end else begin
         kind_r    <= kind_s;
         gid_r     <= gid_s;
         idx_r     <= idx_s;
         wdata_r   <= wdata_s;
         cnt_r     <= cnt_s;
         rr_ptr_r  <= rr_ptr_s;
         dn_rreq_r <= dn_rreq_s;
         dn_wreq_r <= dn_wreq_s;
         rack_r    <= rack_s;
         wack_r    <= wack_s;
         rdata_r   <= rdata_s;
         tmo_r     <= tmo_s;
      end
   end

   assign req_read_ack               = rack_r;
   assign req_write_ack              = wack_r;
   assign req_read_data              = rdata_r;
   assign timeout_error              = tmo_r;
   assign host_interface.read_req    = dn_rreq_r;
   assign host_interface.write_req   = dn_wreq_r;
   assign host_interface.read_index  = idx_r;
   assign host_interface.write_index = idx_r;
   assign host_interface.write_data  = wdata_r;

endmodule
